// File: rtl/register_file_pkg.sv
// Shared widths, index constants and typedefs for the general-purpose register file.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/register_file_if.sv
// Register-file port bundle: two combinational read ports and one write port.
// master drives indices, write enable and write data; slave returns read data the same cycle.
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
);
    logic          RegWrite;
    logic [AW-1:0] Read_register1;
    logic [AW-1:0] Read_register2;
    logic [AW-1:0] Write_register;
    logic [DW-1:0] Write_data;
    logic [DW-1:0] Read_data1;
    logic [DW-1:0] Read_data2;

    modport master (
        output RegWrite, Read_register1, Read_register2, Write_register, Write_data,
        input  Read_data1, Read_data2
    );

    modport slave (
        input  RegWrite, Read_register1, Read_register2, Write_register, Write_data,
        output Read_data1, Read_data2
    );
endinterface

// File: rtl/register_file_read_port.sv
// Combinational read mux over the register array; index zero always reads as zero.
module register_file_read_port
    import regfile_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic [DW-1:0] regs_i [2**AW],
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_o
);

    always_comb begin
        data_o = regs_i[addr_i];
        if (addr_i == AW'(ZERO_REG)) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: synchronous write with reset priority, two independent
// zero-latency read ports without write bypass.
module register_file
    import regfile_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input logic         clk,
    input logic         reset,
    register_file_if.slave rf
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0] regs_q [NREGS];
    logic          wr_en_d;

    // Writes aimed at the zero register are dropped here rather than masked on read only,
    // so the array never holds a stale non-zero value at index zero.
    assign wr_en_d = rf.RegWrite && (rf.Write_register != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[rf.Write_register] <= rf.Write_data;
        end
    end

    register_file_read_port #(.DW(DW), .AW(AW)) u_read_port1 (
        .regs_i (regs_q),
        .addr_i (rf.Read_register1),
        .data_o (rf.Read_data1)
    );

    register_file_read_port #(.DW(DW), .AW(AW)) u_read_port2 (
        .regs_i (regs_q),
        .addr_i (rf.Read_register2),
        .data_o (rf.Read_data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic,
// all reads compared every cycle against an array model of the register contents.
module tb_register_file;

    logic clk;
    logic reset;

    register_file_if rf_if ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain array of register contents.
    logic [31:0] model [32];
    bit          model_valid = 1'b0;
    int          tests_run   = 0;
    int          tests_fail  = 0;

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        return model[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge using the inputs held stable since the previous one.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model_valid = 1'b1;
        end else if (rf_if.RegWrite && rf_if.Write_register != 5'd0) begin
            model[rf_if.Write_register] = rf_if.Write_data;
        end
    end

    // Compare process: both read ports against the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("rd1_vs_model", rf_if.Read_data1, model_read(rf_if.Read_register1));
            check("rd2_vs_model", rf_if.Read_data2, model_read(rf_if.Read_register2));
        end
    end

    // Drive one cycle of inputs, 2 time units after a rising edge.
    task automatic setin(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                         input int r1, input int r2);
        @(posedge clk);
        #2;
        reset                = rst;
        rf_if.RegWrite       = we;
        rf_if.Write_register = 5'(wa);
        rf_if.Write_data     = wd;
        rf_if.Read_register1 = 5'(r1);
        rf_if.Read_register2 = 5'(r2);
    endtask

    task automatic expect2(input string name, input logic [31:0] e1, input logic [31:0] e2);
        #1;
        check({name, "_p1"}, rf_if.Read_data1, e1);
        check({name, "_p2"}, rf_if.Read_data2, e2);
    endtask

    initial begin
        reset                = 1'b1;
        rf_if.RegWrite       = 1'b0;
        rf_if.Write_register = '0;
        rf_if.Write_data     = '0;
        rf_if.Read_register1 = '0;
        rf_if.Read_register2 = '0;

        // Reset held for two edges.
        setin(1, 0, 0, 0, 0, 0);
        setin(1, 0, 0, 0, 0, 0);
        setin(0, 0, 0, 0, 0, 0);
        expect2("reset_r0_r0", 32'h0, 32'h0);
        setin(0, 0, 0, 0, 5, 31);
        expect2("reset_r5_r31", 32'h0, 32'h0);

        // Single write and read-back alongside r0.
        setin(0, 1, 5, 32'h0ABCDEFF, 0, 0);
        setin(0, 0, 0, 0, 5, 0);
        expect2("wr_r5", 32'h0ABCDEFF, 32'h0);
        check("model_pin_r5", model[5], 32'h0ABCDEFF);

        // Successive writes to r10, r15, r20.
        setin(0, 1, 10, 32'h12345678, 0, 0);
        setin(0, 1, 15, 32'h87654321, 0, 0);
        setin(0, 1, 20, 32'hABCDEF01, 0, 0);
        setin(0, 0, 0, 0, 10, 5);
        expect2("rd_10_5", 32'h12345678, 32'h0ABCDEFF);
        setin(0, 0, 0, 0, 15, 10);
        expect2("rd_15_10", 32'h87654321, 32'h12345678);
        setin(0, 0, 0, 0, 20, 15);
        expect2("rd_20_15", 32'hABCDEF01, 32'h87654321);

        // Write to r0 is discarded; RegWrite=0 changes nothing.
        setin(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        setin(0, 0, 5, 32'hDEADBEEF, 0, 0);
        expect2("wr_r0_ignored", 32'h0, 32'h0);
        setin(0, 0, 5, 32'hDEADBEEF, 5, 5);
        expect2("we0_hold_r5", 32'h0ABCDEFF, 32'h0ABCDEFF);

        // Read-during-write on r7: old value before the edge, new value after it.
        setin(0, 1, 7, 32'h00000077, 7, 7);
        expect2("rdw_before", 32'h0, 32'h0);
        @(posedge clk);
        expect2("rdw_after", 32'h00000077, 32'h00000077);
        rf_if.RegWrite = 1'b0;

        // Reset wins over a same-cycle write, then writes resume.
        setin(1, 1, 3, 32'h33333333, 3, 5);
        setin(0, 0, 0, 0, 3, 5);
        expect2("rst_pri_r3_r5", 32'h0, 32'h0);
        setin(0, 0, 0, 0, 20, 7);
        expect2("rst_clr_r20_r7", 32'h0, 32'h0);
        setin(0, 1, 3, 32'h33333333, 0, 0);
        setin(0, 0, 0, 0, 3, 0);
        expect2("wr_after_rst", 32'h33333333, 32'h0);

        // Randomized traffic, checked by the compare process each cycle.
        for (int n = 0; n < 400; n++) begin
            setin(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 31), $urandom,
                  $urandom_range(0, 31), $urandom_range(0, 31));
        end
        setin(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
